nibble_seq_detector: RTL and testbench

- Downstream consumer of the 4-bit D-register stage: samples the registered nibble each clock when enabled and detects a programmable 3-nibble sequence PAT0 -> PAT1 -> PAT2.
- Emits a one-cycle match pulse, keeps a saturating match count, and exposes the FSM state for lab observation and waveform debug.

---
 rtl/nibble_seq_pkg.sv | 12 +
 rtl/nibble_seq_detector_if.sv | 17 +
 rtl/nibble_seq_detector_sat_counter.sv | 20 ++
 rtl/nibble_seq_detector.sv | 60 ++++++
 tb/tb_nibble_seq_detector.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/nibble_seq_pkg.sv
// nibble_seq_pkg: shared FSM state encoding and default pattern nibbles for nibble_seq_detector.
package nibble_seq_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_P0   = 2'd1,
        S_P1   = 2'd2
    } state_t;
    localparam logic [3:0] PAT0_DEF = 4'b0001;
    localparam logic [3:0] PAT1_DEF = 4'b0010;
    localparam logic [3:0] PAT2_DEF = 4'b0100;
endpackage

// File: rtl/nibble_seq_detector_if.sv
// nibble_seq_detector_if: sample/clear inputs and match/status outputs of the nibble sequence detector.
interface nibble_seq_detector_if
    import nibble_seq_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic               en;
    logic [W-1:0]       d;
    logic               clear;
    logic               match;
    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   match_count;
    logic               sticky;
    modport master (output en, d, clear, input match, state, match_count, sticky);
    modport slave  (input en, d, clear, output match, state, match_count, sticky);
endinterface

// File: rtl/nibble_seq_detector_sat_counter.sv
// sat_counter: saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;
    always_comb begin
        count_d = clr ? '0 : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/nibble_seq_detector.sv
// nibble_seq_detector: detects PAT0->PAT1->PAT2 on enabled nibble samples, pulses match, counts matches.
// Optional sticky match flag is built only when NIBBLE_SEQ_STICKY_EN is defined.
module nibble_seq_detector
    import nibble_seq_pkg::*;
#(
    parameter int             W     = 4,
    parameter logic [W-1:0]   PAT0  = PAT0_DEF,
    parameter logic [W-1:0]   PAT1  = PAT1_DEF,
    parameter logic [W-1:0]   PAT2  = PAT2_DEF,
    parameter int             CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    nibble_seq_detector_if.slave bus
);
    state_t state_q, state_d;
    logic   match_q, match_d;
    always_comb begin
        match_d = bus.en && state_q == S_P1 && bus.d == PAT2;
        state_d = S_IDLE;
        // fallback after any miss or completion only re-checks PAT0, never a deeper overlap
        case (state_q)
            S_IDLE:  state_d = (bus.en && bus.d == PAT0) ? S_P0 : S_IDLE;
            S_P0:    state_d = !bus.en ? S_P0 : bus.d == PAT1 ? S_P1 : bus.d == PAT0 ? S_P0 : S_IDLE;
            S_P1:    state_d = !bus.en ? S_P1 : bus.d == PAT0 ? S_P0 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end
    assign bus.state = state_q;
    assign bus.match = match_q;
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (match_d),
        .clr   (bus.clear),
        .count (bus.match_count)
    );
`ifdef NIBBLE_SEQ_STICKY_EN
    logic sticky_q, sticky_d;
    always_comb begin
        sticky_d = bus.clear ? 1'b0 : match_d ? 1'b1 : sticky_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end
    assign bus.sticky = sticky_q;
`else
    assign bus.sticky = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_seq_detector.sv
// tb_nibble_seq_detector: directed and randomized checks of nibble_seq_detector against a prefix-progress model.
module tb_nibble_seq_detector;
    localparam logic [3:0] P0 = 4'b0001;
    localparam logic [3:0] P1 = 4'b0010;
    localparam logic [3:0] P2 = 4'b0100;
    localparam int MAXC = 3;
`ifdef NIBBLE_SEQ_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    int m_prog = 0;
    bit m_match = 0;
    int m_cnt = 0;
    bit m_sticky = 0;
    nibble_seq_detector_if #(.W(4), .CNT_W(2)) bus ();
    nibble_seq_detector #(.W(4), .PAT0(P0), .PAT1(P1), .PAT2(P2), .CNT_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clock = ~clock;
    function automatic logic [5:0] obs();
        return {bus.state, bus.match, bus.match_count, bus.sticky};
    endfunction
    function automatic logic [5:0] expv();
        return {2'(m_prog), m_match, 2'(m_cnt), STICKY & m_sticky};
    endfunction
    task automatic model_reset();
        m_prog = 0; m_match = 0; m_cnt = 0; m_sticky = 0;
    endtask
    // m_prog is the length of the pattern prefix currently matched (0..2)
    task automatic step(input bit e, input logic [3:0] dv, input bit c);
        bus.en = e; bus.d = dv; bus.clear = c;
        @(posedge clock);
        m_match = e && m_prog == 2 && dv == P2;
        if (e) m_prog = (m_prog == 1 && dv == P1) ? 2 : (dv == P0 ? 1 : 0);
        m_cnt = c ? 0 : m_match ? (m_cnt == MAXC ? MAXC : m_cnt + 1) : m_cnt;
        m_sticky = c ? 1'b0 : m_match ? 1'b1 : m_sticky;
        #1;
    endtask
    task automatic test_reset();
        reset = 1'b0; bus.en = 1'b1; bus.d = P2; bus.clear = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            #(i == 0 ? 4 : 5);
            checks++;
            if (obs() !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold t=%0t got %b want %b", $time, obs(), 6'b0);
            end
        end
        #2 reset = 1'b1;
        step(1, P2, 0);
        checks++;
        if (obs() !== expv() || bus.match !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got %b want %b", obs(), expv());
        end
    endtask
    task automatic test_basic();
        logic [3:0] ds [3] = '{P0, P1, P2};
        logic [1:0] st [3] = '{2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            step(1, ds[i], 0);
            checks++;
            if (obs() !== expv() || bus.state !== st[i] || bus.match !== (i == 2)) begin
                errors++;
                $display("FAIL basic i=%0d got %b want %b state_want %0d", i, obs(), expv(), st[i]);
            end
        end
        step(1, 4'hF, 0);
        checks++;
        if (obs() !== expv() || bus.match !== 1'b0 || bus.match_count !== 2'd1) begin
            errors++;
            $display("FAIL basic_pulse got %b want %b", obs(), expv());
        end
    endtask
    task automatic test_fallback();
        logic [3:0] ds [4] = '{P0, P0, P1, 4'b1000};
        logic [1:0] st [4] = '{2'd1, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 4; i++) begin
            step(1, ds[i], 0);
            checks++;
            if (obs() !== expv() || bus.state !== st[i] || bus.match !== 1'b0 || bus.match_count !== 2'd1) begin
                errors++;
                $display("FAIL fallback i=%0d got %b want %b state_want %0d", i, obs(), expv(), st[i]);
            end
        end
    endtask
    task automatic test_enable();
        bit         es [6] = '{1, 1, 0, 0, 0, 1};
        logic [3:0] ds [6] = '{P0, P1, P2, P2, P2, P2};
        logic [1:0] st [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        for (int i = 0; i < 6; i++) begin
            step(es[i], ds[i], 0);
            checks++;
            if (obs() !== expv() || bus.state !== st[i] || bus.match !== (i == 5)) begin
                errors++;
                $display("FAIL enable i=%0d got %b want %b state_want %0d", i, obs(), expv(), st[i]);
            end
        end
    endtask
    task automatic test_saturation_clear();
        step(0, 4'h0, 1);
        for (int n = 0; n < 6; n++) begin
            step(1, P0, 0);
            step(1, P1, 0);
            step(1, P2, n == 5);
            checks++;
            if (obs() !== expv() || bus.match !== 1'b1) begin
                errors++;
                $display("FAIL saturate n=%0d got %b want %b", n, obs(), expv());
            end
            if (n == 4) begin
                checks++;
                if (bus.match_count !== 2'd3) begin
                    errors++;
                    $display("FAIL saturate_hold got %0d want 3", bus.match_count);
                end
            end
        end
        checks++;
        if (bus.match_count !== 2'd0 || bus.sticky !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins count=%0d sticky=%0b want 0 0", bus.match_count, bus.sticky);
        end
    endtask
    task automatic test_async_reset();
        step(1, P0, 0);
        step(1, P1, 0);
        #3 reset = 1'b0;
        #1 model_reset();
        checks++;
        if (obs() !== expv() || bus.state !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got %b want %b", obs(), expv());
        end
        #2 reset = 1'b1;
        step(1, P2, 0);
        checks++;
        if (obs() !== expv() || bus.match !== 1'b0) begin
            errors++;
            $display("FAIL async_partial got %b want %b", obs(), expv());
        end
        step(1, P0, 0);
        step(1, P1, 0);
        step(1, P2, 0);
        checks++;
        if (obs() !== expv() || bus.sticky !== STICKY) begin
            errors++;
            $display("FAIL sticky_set got %b want %b", obs(), expv());
        end
        step(0, P2, 1);
        checks++;
        if (obs() !== expv() || bus.sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear got %b want %b", obs(), expv());
        end
    endtask
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int pick = $urandom_range(0, 3);
            logic [3:0] dv = pick == 0 ? P0 : pick == 1 ? P1 : pick == 2 ? P2 : 4'($urandom);
            step($urandom_range(0, 3) != 0, dv, $urandom_range(0, 19) == 0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random i=%0d got %b want %b", i, obs(), expv());
            end
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_fallback();
        test_enable();
        test_saturation_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
